// File: rtl/mux_n_pipe.sv
// mux_n_pipe: pipelined N:1 multiplexer of W-bit words, one registered tree level per select bit.
// Auto-scan (internal channel counter driving the select) is built only when MUX_PIPE_SCAN_EN is defined.
module mux_n_pipe #(
    parameter  int W = 8,
    parameter  int N = 8,
    localparam int L = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] i,
    input  logic [L-1:0]   s,
    input  logic           mode,
    input  logic           in_valid,
    input  logic           en,
    output logic [W-1:0]   f,
    output logic           f_valid,
    output logic [L-1:0]   f_ch
);

    logic [L-1:0] sel;

`ifdef MUX_PIPE_SCAN_EN
    logic [L-1:0] cnt;

    // N is a power of two, so the natural L-bit rollover is the N-1 -> 0 wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (!mode)         cnt <= '0;
            else if (in_valid) cnt <= cnt + 1'b1;
        end
    end

    assign sel = mode ? cnt : s;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign sel         = s;
`endif

    // Tree nodes of all levels packed back to back: level k occupies N>>k words.
    // 'all' prepends the raw channel words so every level reads from one array.
    logic [N-1:0][W-1:0]   iw;
    logic [N-2:0][W-1:0]   node;
    logic [2*N-2:0][W-1:0] all;
    logic [L:1][L-1:0]     tag_r;
    logic [L:0][L-1:0]     tag_pipe;
    logic [L:1]            vld_r;
    logic [L:0]            vld_pipe;

    assign iw       = i;
    assign all      = {node, iw};
    assign tag_pipe = {tag_r, sel};
    assign vld_pipe = {vld_r, in_valid};

    // Start of level k's inputs inside 'all'; its outputs start at half that in 'node'.
    function automatic int base(input int k);
        return 2*N - ((2*N) >> (k-1));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node  <= '0;
            tag_r <= '0;
            vld_r <= '0;
        end else if (en) begin
            for (int k = 1; k <= L; k++) begin
                // each level steers with the select bit carried by its own word
                for (int j = 0; j < (N >> k); j++) begin
                    node[base(k)/2 + j] <= tag_pipe[k-1][k-1] ? all[base(k) + 2*j + 1]
                                                              : all[base(k) + 2*j];
                end
                tag_r[k] <= tag_pipe[k-1];
                vld_r[k] <= vld_pipe[k-1];
            end
        end
    end

    assign f       = all[2*N-2];
    assign f_valid = vld_r[L];
    assign f_ch    = tag_r[L];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe (N=8, W=8): expected words are queued at the sampling
// edge with the enabled-edge count at which they must emerge, and checked when f_valid shows.
module tb_mux_n_pipe;
    localparam int W = 8;
    localparam int N = 8;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] i;
    logic [L-1:0]   s;
    logic           mode;
    logic           in_valid;
    logic           en;
    logic [W-1:0]   f;
    logic           f_valid;
    logic [L-1:0]   f_ch;

    mux_n_pipe #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .s(s), .mode(mode), .in_valid(in_valid),
        .en(en), .f(f), .f_valid(f_valid), .f_ch(f_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [L-1:0] ch;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    int           en_edges = 0;
    logic         last_en = 1'b0;
    logic [L-1:0] cnt_m = '0;
    logic [W-1:0] pf = '0;
    logic         pv = 1'b0;
    logic [L-1:0] pc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // reference: sample the inputs on every enabled edge
    always @(posedge clk) begin
        logic [L-1:0] sel_m;
        exp_t e;
        if (rst_n && en) begin
            en_edges++;
`ifdef MUX_PIPE_SCAN_EN
            sel_m = mode ? cnt_m : s;
            if (!mode)         cnt_m = '0;
            else if (in_valid) cnt_m = cnt_m + 1'b1;
`else
            sel_m = s;
`endif
            if (in_valid) begin
                e.d   = i[sel_m*W +: W];
                e.ch  = sel_m;
                e.due = en_edges + L - 1;
                sb.push_back(e);
            end
        end
        last_en = rst_n && en;
    end

    // monitor away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!last_en) begin
                chk("hold_f", f, pf);
                chk("hold_valid", f_valid, pv);
                chk("hold_ch", f_ch, pc);
            end else if (f_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data", f, e.d);
                    chk("ch", f_ch, e.ch);
                    chk("latency", en_edges, e.due);
                end
            end else if (sb.size() != 0) begin
                chk("missing_word", sb[0].due > en_edges, 1);
            end
        end
        pf = f;
        pv = f_valid;
        pc = f_ch;
    end

    task automatic drive(input logic v, input logic [L-1:0] sv, input logic md, input logic e);
        in_valid = v;
        s        = sv;
        mode     = md;
        en       = e;
        @(posedge clk);
        #1;
    endtask

    task automatic std_data();
        for (int c = 0; c < N; c++) i[c*W +: W] = 8'h10 + c[7:0];
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; s = '0; mode = 1'b0; en = 1'b0;
        std_data();
        #1;
        chk("reset_f", f, 0);
        chk("reset_valid", f_valid, 0);
        chk("reset_ch", f_ch, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // static select
        repeat (6) drive(1'b1, 3'd5, 1'b0, 1'b1);
        // per-word select, back to back
        for (int k = 0; k < N; k++) drive(1'b1, k[2:0], 1'b0, 1'b1);
        // stall mid-stream
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 3'd3, 1'b0, 1'b1);
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        for (int k = 4; k < 8; k++) drive(1'b1, k[2:0], 1'b0, 1'b1);
        // single bubble
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        drive(1'b0, 3'd4, 1'b0, 1'b1);
        drive(1'b1, 3'd6, 1'b0, 1'b1);

        // auto-scan with wrap, a dropped in_valid, and mode 1->0->1 restart
        repeat (10) drive(1'b1, 3'd3, 1'b1, 1'b1);
        drive(1'b0, 3'd3, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 3'd3, 1'b1, 1'b1);
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 3'd6, 1'b1, 1'b1);
        drive(1'b1, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 3'd6, 1'b1, 1'b1);

        // randomized traffic with random channel data
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < N; c++) i[c*W +: W] = 8'($urandom);
            drive(1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) != 0));
        end
        std_data();

        // asynchronous reset mid-stream: outputs clear at once, in-flight words dropped
        repeat (2) drive(1'b1, 3'd4, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        sb.delete();
        cnt_m = '0;
        #1;
        chk("async_reset_f", f, 0);
        chk("async_reset_valid", f_valid, 0);
        chk("async_reset_ch", f_ch, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        drive(1'b1, 3'd0, 1'b1, 1'b1);

        // drain
        repeat (L + 2) drive(1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
